// File: rtl/flappy_pkg.sv
// flappy_pkg: shared geometry constants and play-state encoding for the flappy datapath.
`default_nettype none

package flappy_pkg;

  localparam int ROWS     = 30;
  localparam int COLS     = 32;
  localparam int COL_W    = 5;
  localparam int BIRD_COL = 8;
  localparam int SCORE_W  = 8;
  localparam int ROW_W    = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    GAMEOVER = 2'd2
  } game_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_column_buffer.sv
// pipe_column_buffer: scrolling column window with clear, left shift, registered read port
// and bird-column taps.
`default_nettype none

module pipe_column_buffer
  import flappy_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             shift,
  input  logic [ROWS-1:0]  dim_in,
  input  logic [COL_W-1:0] rd_col,
  output logic [ROWS-1:0]  rd_data,
  output logic [ROWS-1:0]  tap_bird,
  output logic [ROWS-1:0]  tap_next
);

  logic [ROWS-1:0] col_q [COLS];
  logic [ROWS-1:0] col_d [COLS];
  logic [ROWS-1:0] rd_data_q;
  logic [ROWS-1:0] rd_data_d;

  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      col_d[i] = col_q[i];
    end
    if (clear) begin
      for (int i = 0; i < COLS; i++) begin
        col_d[i] = '0;
      end
    end else if (shift) begin
      for (int i = 0; i < COLS - 1; i++) begin
        col_d[i] = col_q[i + 1];
      end
      col_d[COLS-1] = dim_in;
    end

    // Read samples the pre-edge window, so a read never sees a same-cycle shift.
    rd_data_d = '0;
    if (int'(rd_col) < COLS) begin
      rd_data_d = col_q[rd_col];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < COLS; i++) begin
        col_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      col_q     <= col_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign tap_bird = col_q[BIRD_COL];
  assign tap_next = col_q[BIRD_COL+1];

endmodule

`default_nettype wire

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: play-state FSM, bird/pipe collision and score around the column window.
`default_nettype none

module obstacle_scroller
  import flappy_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               scroll_en,
  input  logic [ROWS-1:0]    dim_in,
  input  logic [ROW_W-1:0]   bird_row,
  input  logic [COL_W-1:0]   rd_col,
  output logic [ROWS-1:0]    rd_data,
  output logic               collision,
  output logic               game_over,
  output logic               running,
  output logic [SCORE_W-1:0] score
);

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               collision_q, collision_d;
  logic               game_over_q, game_over_d;
  logic               running_q, running_d;
  logic [ROWS-1:0]    tap_bird;
  logic [ROWS-1:0]    tap_next;
  logic               hit;
  logic               buf_clear;
  logic               buf_shift;

  pipe_column_buffer u_buffer (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (buf_clear),
    .shift    (buf_shift),
    .dim_in   (dim_in),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .tap_bird (tap_bird),
    .tap_next (tap_next)
  );

  always_comb begin
    hit = (bird_row >= ROW_W'(ROWS)) ? 1'b1 : tap_bird[bird_row];

    state_d     = state_q;
    score_d     = score_q;
    collision_d = 1'b0;
    buf_clear   = 1'b0;
    buf_shift   = 1'b0;

    case (state_q)
      IDLE, GAMEOVER: begin
        if (start) begin
          state_d   = RUN;
          buf_clear = 1'b1;
          score_d   = '0;
        end
      end
      RUN: begin
        if (hit) begin
          state_d     = GAMEOVER;
          collision_d = 1'b1;
        end else if (scroll_en) begin
          buf_shift = 1'b1;
          // A pipe scores when its last column leaves the bird column.
          if ((tap_bird != '0) && (tap_next == '0) && (score_q != '1)) begin
            score_d = score_q + SCORE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == GAMEOVER);
    running_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      score_q     <= '0;
      collision_q <= 1'b0;
      game_over_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      collision_q <= collision_d;
      game_over_q <= game_over_d;
      running_q   <= running_d;
    end
  end

  assign collision = collision_q;
  assign game_over = game_over_q;
  assign running   = running_q;
  assign score     = score_q;

endmodule

`default_nettype wire
